risc_core_mc: RTL and testbench

- Parametrised multi-cycle successor to the 8-bit paged RISC core.
- Four general registers; the 8-bit instruction encoding is unchanged; data width is set by DATA_W.
- Instruction, data and stack memory sit behind one external req/ack port, so wait-state memory is supported.
- Adds a blocking input handshake, an output strobe, an illegal-opcode flag and a halted status output.

---
 rtl/risc_core_mc.sv | 209 ++++++++++++++++++++
 tb/tb_risc_core_mc.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/risc_core_mc.sv
// risc_core_mc: multi-cycle 4-register core with paged memory behind one
// req/ack port, blocking IN handshake, OUT strobe and illegal-opcode flag.
module risc_core_mc #(
    parameter int                DATA_W   = 8,
    parameter logic [DATA_W-1:0] RESET_PC = '0,
    parameter logic [DATA_W-1:0] RESET_SP = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [2*DATA_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic                  mem_ack,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic                  out_valid,
    output logic [DATA_W-1:0]     out_data,
    input  logic                  in_valid,
    input  logic [DATA_W-1:0]     in_data,
    output logic                  in_ready,
    output logic                  halted,
    output logic                  illegal
);
    typedef enum logic [2:0] {
        FETCH, EXEC, MEM, WAIT_IN, HALTED
    } state_t;

    state_t state, state_nx;
    logic boot;
    logic [3:0][DATA_W-1:0] r, r_nx;
    logic [DATA_W-1:0] pc, pc_nx, sp, sp_nx;
    logic [DATA_W-1:0] ipage, ipage_nx, dpage, dpage_nx, spage, spage_nx;
    logic [7:0] ir, ir_nx;

    logic [3:0] op;
    logic [1:0] rd, rs;
    logic [3:0] imm;
    logic [DATA_W-1:0] rdv, rsv, pc1;
    logic skip;

    assign op  = ir[7:4];
    assign rd  = ir[3:2];
    assign rs  = ir[1:0];
    assign imm = {ir[5:4], ir[1:0]};
    assign rdv = r[rd];
    assign rsv = r[rs];
    assign pc1 = pc + DATA_W'(1);

    assign halted   = (state == HALTED);
    assign out_data = rdv;

    always_comb begin
        skip = 1'b0;
        unique case (rs)
            2'b00: skip = (rdv == '0);
            2'b01: skip = (rdv != '0);
            2'b10: skip = rdv[DATA_W-1];
            2'b11: skip = !rdv[DATA_W-1];
        endcase
    end

    // Address/data held stable from EXEC state across all MEM wait cycles
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = {ipage, pc};
        mem_wdata = rdv;
        if (state == FETCH) begin
            mem_req = !boot;
        end else if (state == MEM) begin
            mem_req = 1'b1;
            if (op == 4'h2) begin
                mem_addr = {dpage, rsv};
            end else if (op == 4'h3) begin
                mem_we   = 1'b1;
                mem_addr = {dpage, rsv};
            end else if (rs == 2'b00) begin
                mem_we   = 1'b1;
                mem_addr = {spage, sp - DATA_W'(1)};
            end else begin
                mem_addr = {spage, sp};
            end
        end
    end

    always_comb begin
        state_nx  = state;
        r_nx      = r;
        pc_nx     = pc;
        sp_nx     = sp;
        ipage_nx  = ipage;
        dpage_nx  = dpage;
        spage_nx  = spage;
        ir_nx     = ir;
        out_valid = 1'b0;
        in_ready  = 1'b0;
        illegal   = 1'b0;
        unique case (state)
            FETCH: begin
                if (!boot && mem_ack) begin
                    ir_nx    = mem_rdata[7:0];
                    state_nx = EXEC;
                end
            end
            EXEC: begin
                state_nx = FETCH;
                pc_nx    = pc1;
                case (op)
                    4'h0: begin
                        if (ir == 8'h01) begin
                            state_nx = HALTED;
                            pc_nx    = pc;
                        end else if (ir != 8'h00) begin
                            dpage_nx = rdv;
                        end
                    end
                    4'h1: r_nx[rd] = rdv - rsv;
                    4'h2, 4'h3: begin
                        state_nx = MEM;
                        pc_nx    = pc;
                    end
                    4'h4: if (skip) pc_nx = pc + DATA_W'(2);
                    4'h5: begin
                        pc_nx    = rsv;
                        r_nx[rd] = pc1;
                    end
                    4'h6: r_nx[rd] = ~(rdv & rsv);
                    4'h7: r_nx[rd] = rdv + rsv;
                    4'h8: begin
                        unique case (rs)
                            2'b00: r_nx[rd] = rdv + DATA_W'(1);
                            2'b01: r_nx[rd] = rdv - DATA_W'(1);
                            2'b10: out_valid = 1'b1;
                            2'b11: begin
                                state_nx = WAIT_IN;
                                pc_nx    = pc;
                            end
                        endcase
                    end
                    4'h9: begin
                        ipage_nx = r[2];
                        pc_nx    = rdv;
                        r_nx[rs] = pc1;
                    end
                    4'hA: begin
                        unique case (rs)
                            2'b00, 2'b01: begin
                                state_nx = MEM;
                                pc_nx    = pc;
                            end
                            2'b10: spage_nx = rdv;
                            2'b11: ;
                        endcase
                    end
                    4'hB: illegal = 1'b1;
                    default: r_nx[rd] = {rdv[DATA_W-5:0], imm};
                endcase
            end
            MEM: begin
                if (mem_ack) begin
                    state_nx = FETCH;
                    pc_nx    = pc1;
                    if (op == 4'h2) begin
                        r_nx[rd] = mem_rdata;
                    end else if (op == 4'hA && rs == 2'b00) begin
                        sp_nx = sp - DATA_W'(1);
                    end else if (op == 4'hA) begin
                        r_nx[rd] = mem_rdata;
                        sp_nx    = sp + DATA_W'(1);
                    end
                end
            end
            WAIT_IN: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    r_nx[rd] = in_data;
                    pc_nx    = pc1;
                    state_nx = FETCH;
                end
            end
            HALTED: ;
        endcase
    end

    // boot masks the request for one cycle so reset visibly drops mem_req
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FETCH;
            boot  <= 1'b1;
            r     <= '0;
            pc    <= RESET_PC;
            sp    <= RESET_SP;
            ipage <= '0;
            dpage <= '0;
            spage <= '0;
            ir    <= '0;
        end else begin
            state <= state_nx;
            boot  <= 1'b0;
            r     <= r_nx;
            pc    <= pc_nx;
            sp    <= sp_nx;
            ipage <= ipage_nx;
            dpage <= dpage_nx;
            spage <= spage_nx;
            ir    <= ir_nx;
        end
    end
endmodule

// File: tb/tb_risc_core_mc.sv
// tb_risc_core_mc: directed programs against a req/ack memory model
// with configurable wait states.
module tb_risc_core_mc;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_req, mem_we, mem_ack;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata, mem_rdata;
    logic        out_valid, in_valid, in_ready, halted, illegal;
    logic [7:0]  out_data, in_data;

    int tests = 0;
    int failed = 0;

    logic [7:0]  mem [0:65535];
    int          wait_n = 0;
    int          cnt = 0;
    logic [15:0] reads [$];
    logic [15:0] waddrs [$];
    logic [7:0]  wdatas [$];
    logic [7:0]  outs [$];
    int          ill_cycles, active, unstable, req_halt;
    logic        started, pend, p_we;
    logic [15:0] p_addr;
    logic [7:0]  p_wdata;

    always #5 clk = ~clk;

    risc_core_mc #(.DATA_W(8)) dut (
        .clk(clk), .rst(rst),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .out_valid(out_valid), .out_data(out_data),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .halted(halted), .illegal(illegal)
    );

    assign mem_ack   = mem_req && (cnt >= wait_n);
    assign mem_rdata = mem[mem_addr];

    always @(posedge clk)
        cnt <= (mem_req && !mem_ack) ? cnt + 1 : 0;

    task automatic monitor();
        forever begin
            @(negedge clk);
            if (mem_req && mem_ack) begin
                if (mem_we) begin
                    mem[mem_addr] = mem_wdata;
                    waddrs.push_back(mem_addr);
                    wdatas.push_back(mem_wdata);
                end else begin
                    reads.push_back(mem_addr);
                end
            end
            if (pend && mem_req && (mem_addr !== p_addr || mem_we !== p_we ||
                (mem_we && mem_wdata !== p_wdata)))
                unstable++;
            pend    = mem_req && !mem_ack;
            p_addr  = mem_addr;
            p_we    = mem_we;
            p_wdata = mem_wdata;
            if (out_valid) outs.push_back(out_data);
            if (illegal) ill_cycles++;
            if (mem_req && halted) req_halt++;
            if (rst) started = 1'b0;
            else if (mem_req) started = 1'b1;
            if (started && !halted) active++;
        end
    endtask

    task automatic clear_log();
        reads.delete();
        waddrs.delete();
        wdatas.delete();
        outs.delete();
        ill_cycles = 0;
        active = 0;
        unstable = 0;
        req_halt = 0;
        started = 1'b0;
        pend = 1'b0;
    endtask

    task automatic do_reset(input int w);
        @(negedge clk);
        rst = 1'b1;
        wait_n = w;
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        @(posedge clk);
        clear_log();
        @(posedge clk);
    endtask

    task automatic release_rst();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_halt(input int budget);
        int i;
        for (i = 0; i < budget && !halted; i++) @(negedge clk);
        tests++;
        if (!halted) begin
            failed++;
            $display("FAIL halt_timeout: halted=%b want 1", halted);
        end
    endtask

    task automatic load_prog0();
        logic [7:0] p [7] = '{8'hC1, 8'hC2, 8'hC8, 8'hCB, 8'h72, 8'h82, 8'h01};
        foreach (p[i]) mem[i] = p[i];
    endtask

    task automatic test_reset();
        do_reset(0);
        load_prog0();
        @(negedge clk);
        tests++;
        if ({mem_req, out_valid, in_ready, halted, illegal} !== 5'b0) begin
            failed++;
            $display("FAIL reset_outputs: got %b want 00000",
                     {mem_req, out_valid, in_ready, halted, illegal});
        end
        release_rst();
        @(negedge clk);
        tests++;
        if (mem_req !== 1'b1 || mem_addr !== 16'h0000 || mem_we !== 1'b0) begin
            failed++;
            $display("FAIL reset_first_fetch: req=%b addr=%h we=%b want 1 0000 0",
                     mem_req, mem_addr, mem_we);
        end
    endtask

    task automatic test_prog(input int w, input int cycles);
        do_reset(w);
        load_prog0();
        release_rst();
        wait_halt(200);
        repeat (5) @(negedge clk);
        tests++;
        if (outs.size() != 1 || outs[0] !== 8'h15) begin
            failed++;
            $display("FAIL prog_out_w%0d: n=%0d first=%h want 1 15", w, outs.size(),
                     outs.size() > 0 ? outs[0] : 8'hxx);
        end
        tests++;
        if (active != cycles) begin
            failed++;
            $display("FAIL prog_cycles_w%0d: got %0d want %0d", w, active, cycles);
        end
        tests++;
        if (req_halt != 0 || unstable != 0) begin
            failed++;
            $display("FAIL prog_bus_w%0d: req_after_halt=%0d unstable=%0d want 0 0",
                     w, req_halt, unstable);
        end
    endtask

    task automatic test_stack();
        logic [7:0] p [7] = '{8'hD5, 8'hE6, 8'hA4, 8'hAD, 8'h8E, 8'hA4, 8'h01};
        do_reset(1);
        foreach (p[i]) mem[i] = p[i];
        release_rst();
        wait_halt(200);
        tests++;
        if (waddrs.size() != 2 || waddrs[0] !== 16'h00FF || wdatas[0] !== 8'h5A) begin
            failed++;
            $display("FAIL push_write: n=%0d addr=%h data=%h want 2 00FF 5A",
                     waddrs.size(), waddrs.size() > 0 ? waddrs[0] : 16'hxxxx,
                     wdatas.size() > 0 ? wdatas[0] : 8'hxx);
        end
        tests++;
        if (outs.size() != 1 || outs[0] !== 8'h5A) begin
            failed++;
            $display("FAIL pop_value: n=%0d r3=%h want 1 5A", outs.size(),
                     outs.size() > 0 ? outs[0] : 8'hxx);
        end
        tests++;
        if (waddrs.size() != 2 || waddrs[1] !== 16'h00FF) begin
            failed++;
            $display("FAIL sp_restored: second push addr=%h want 00FF",
                     waddrs.size() > 1 ? waddrs[1] : 16'hxxxx);
        end
    endtask

    task automatic test_skip();
        logic [7:0] p [11] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h40, 8'h01,
                               8'hE0, 8'hC0, 8'h43, 8'h82, 8'h01};
        do_reset(0);
        foreach (p[i]) mem[i] = p[i];
        release_rst();
        wait_halt(200);
        tests++;
        if (reads.size() != 10 || reads[5] !== 16'h0006) begin
            failed++;
            $display("FAIL skipz_taken: n=%0d fetch=%h want 10 0006", reads.size(),
                     reads.size() > 5 ? reads[5] : 16'hxxxx);
        end
        tests++;
        if (reads.size() != 10 || reads[8] !== 16'h0009) begin
            failed++;
            $display("FAIL skipge_not_taken: fetch=%h want 0009",
                     reads.size() > 8 ? reads[8] : 16'hxxxx);
        end
        tests++;
        if (outs.size() != 1 || outs[0] !== 8'h80) begin
            failed++;
            $display("FAIL skip_r0: n=%0d r0=%h want 1 80", outs.size(),
                     outs.size() > 0 ? outs[0] : 8'hxx);
        end
    endtask

    task automatic test_alu();
        logic [7:0] p [15] = '{8'hC1, 8'hC2, 8'hD5, 8'h11, 8'h82, 8'h61, 8'h82,
                               8'h85, 8'h86, 8'h04, 8'h29, 8'h8A, 8'h84, 8'h86,
                               8'h01};
        logic [7:0] exp [5] = '{8'h0D, 8'hFA, 8'h04, 8'h77, 8'h05};
        do_reset(2);
        foreach (p[i]) mem[i] = p[i];
        mem[16'h0404] = 8'h77;
        release_rst();
        wait_halt(400);
        tests++;
        if (outs.size() != 5) begin
            failed++;
            $display("FAIL alu_count: got %0d want 5", outs.size());
        end
        foreach (exp[i]) begin
            tests++;
            if (outs.size() <= i || outs[i] !== exp[i]) begin
                failed++;
                $display("FAIL alu_out%0d: got %h want %h", i,
                         outs.size() > i ? outs[i] : 8'hxx, exp[i]);
            end
        end
    endtask

    task automatic test_jump();
        do_reset(0);
        mem[0] = 8'hC1; mem[1] = 8'hC0; mem[2] = 8'h54;
        mem[16'h10] = 8'h86; mem[16'h11] = 8'hC9; mem[16'h12] = 8'hCE;
        mem[16'h13] = 8'hCC; mem[16'h14] = 8'h9C;
        mem[16'h0120] = 8'h82; mem[16'h0121] = 8'h01;
        release_rst();
        wait_halt(200);
        tests++;
        if (outs.size() != 2 || outs[0] !== 8'h03 || outs[1] !== 8'h15) begin
            failed++;
            $display("FAIL jump_links: n=%0d o0=%h o1=%h want 2 03 15", outs.size(),
                     outs.size() > 0 ? outs[0] : 8'hxx,
                     outs.size() > 1 ? outs[1] : 8'hxx);
        end
        tests++;
        if (reads.size() != 10 || reads[3] !== 16'h0010 || reads[9] !== 16'h0121) begin
            failed++;
            $display("FAIL jump_targets: n=%0d r3=%h r9=%h want 10 0010 0121",
                     reads.size(), reads.size() > 3 ? reads[3] : 16'hxxxx,
                     reads.size() > 9 ? reads[9] : 16'hxxxx);
        end
    endtask

    task automatic test_in();
        int i;
        logic ok = 1'b1;
        do_reset(0);
        mem[0] = 8'h8B; mem[1] = 8'h8A; mem[2] = 8'h01;
        in_valid = 1'b0;
        in_data  = 8'h00;
        release_rst();
        for (i = 0; i < 20 && !in_ready; i++) @(negedge clk);
        tests++;
        if (!in_ready) begin
            failed++;
            $display("FAIL in_ready_rise: got %b want 1", in_ready);
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (in_ready !== 1'b1 || mem_req !== 1'b0) ok = 1'b0;
        end
        tests++;
        if (!ok) begin
            failed++;
            $display("FAIL in_wait_hold: ready/idle held=%b want 1", ok);
        end
        in_valid = 1'b1;
        in_data  = 8'h3C;
        @(negedge clk);
        in_valid = 1'b0;
        tests++;
        if (in_ready !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 16'h0001) begin
            failed++;
            $display("FAIL in_resume: ready=%b req=%b addr=%h want 0 1 0001",
                     in_ready, mem_req, mem_addr);
        end
        wait_halt(100);
        tests++;
        if (outs.size() != 1 || outs[0] !== 8'h3C) begin
            failed++;
            $display("FAIL in_value: n=%0d r2=%h want 1 3C", outs.size(),
                     outs.size() > 0 ? outs[0] : 8'hxx);
        end
    endtask

    task automatic test_reset_mem();
        int i;
        do_reset(3);
        mem[0] = 8'hD5; mem[1] = 8'h34;
        release_rst();
        for (i = 0; i < 50 && !(mem_req && mem_we); i++) @(negedge clk);
        rst = 1'b1;
        mem[0] = 8'h86;
        mem[1] = 8'h01;
        @(negedge clk);
        tests++;
        if (mem_req !== 1'b0 || waddrs.size() != 0) begin
            failed++;
            $display("FAIL reset_abort: req=%b writes=%0d want 0 0",
                     mem_req, waddrs.size());
        end
        @(posedge clk);
        clear_log();
        release_rst();
        wait_halt(100);
        tests++;
        if (reads.size() == 0 || reads[0] !== 16'h0000) begin
            failed++;
            $display("FAIL reset_refetch: addr=%h want 0000",
                     reads.size() > 0 ? reads[0] : 16'hxxxx);
        end
        tests++;
        if (outs.size() != 1 || outs[0] !== 8'h00) begin
            failed++;
            $display("FAIL reset_regs: r1=%h want 00",
                     outs.size() > 0 ? outs[0] : 8'hxx);
        end
    endtask

    task automatic test_illegal();
        do_reset(0);
        mem[0] = 8'hB0; mem[1] = 8'h01;
        release_rst();
        wait_halt(50);
        tests++;
        if (ill_cycles != 1) begin
            failed++;
            $display("FAIL illegal_pulse: cycles=%0d want 1", ill_cycles);
        end
        tests++;
        if (reads.size() != 2 || reads[1] !== 16'h0001) begin
            failed++;
            $display("FAIL illegal_pc: n=%0d next=%h want 2 0001", reads.size(),
                     reads.size() > 1 ? reads[1] : 16'hxxxx);
        end
    endtask

    initial begin
        in_valid = 1'b0;
        in_data  = 8'h00;
        clear_log();
        fork
            monitor();
        join_none
        test_reset();
        test_prog(0, 14);
        test_prog(3, 35);
        test_stack();
        test_skip();
        test_alu();
        test_jump();
        test_in();
        test_reset_mem();
        test_illegal();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
